odd_pipe_wb_align: RTL and testbench

- Parametrised result-alignment and forwarding pipeline for the SPU-Lite odd pipe.
- Generalises the fixed six-stage odd-pipe forwarding taps (stages 2..7) to DEPTH stages with per-unit latencies.
- Tracks each issued odd-pipe instruction, captures unit results at that unit's latency, and exposes per-stage forwarding taps.
- Drives one aligned register-file write at stage DEPTH and supports a branch-mispredict flush of younger instructions.

---
 rtl/odd_pipe_wb_align.sv | 161 ++++++++++++++++
 tb/tb_odd_pipe_wb_align.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/odd_pipe_wb_align.sv
// odd_pipe_wb_align: result-alignment and forwarding pipeline for the odd pipe.
//
// Each issued instruction walks through DEPTH stages. The result of its
// execution unit is captured when the instruction sits in the stage equal to
// that unit's latency, so every instruction reaches writeback at stage DEPTH
// with its data already aligned.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   issue_*             instruction issued this cycle (unit, RT write enable, RT address)
//   br/perm/ls_data     unit results for the instruction in stage BR/PERM/LS_LAT
//   flush               mispredicted branch in stage BR_LAT; kills younger work
//   fwd_valid/addr/data per-stage forwarding taps (stage k at bit/slice k-1)
//   wb_en/addr/data     register-file write port (stage DEPTH)
//   inflight            number of valid stages
module odd_pipe_wb_align #(
   parameter int unsigned REG_ADDR_WD = 7,
   parameter int unsigned REG_DATA_WD = 128,
   parameter int unsigned DEPTH       = 7,
   parameter int unsigned BR_LAT      = 1,
   parameter int unsigned PERM_LAT    = 3,
   parameter int unsigned LS_LAT      = 6
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           issue_valid,
   input  logic [1:0]                     issue_unit,
   input  logic                           issue_wr_en,
   input  logic [REG_ADDR_WD-1:0]         issue_rt_addr,
   input  logic [REG_DATA_WD-1:0]         br_data,
   input  logic [REG_DATA_WD-1:0]         perm_data,
   input  logic [REG_DATA_WD-1:0]         ls_data,
   input  logic                           flush,
   output logic [DEPTH-1:0]               fwd_valid,
   output logic [DEPTH*REG_ADDR_WD-1:0]   fwd_addr,
   output logic [DEPTH*REG_DATA_WD-1:0]   fwd_data,
   output logic                           wb_en,
   output logic [REG_ADDR_WD-1:0]         wb_addr,
   output logic [REG_DATA_WD-1:0]         wb_data,
   output logic [4:0]                     inflight
);

   localparam logic [1:0] UNIT_PERM = 2'd0;
   localparam logic [1:0] UNIT_LS   = 2'd1;
   localparam logic [1:0] UNIT_BR   = 2'd2;
   localparam logic [1:0] UNIT_NONE = 2'd3;

   // Array index i holds pipe stage i+1.
   logic                   valid_q [DEPTH];
   logic                   valid_d [DEPTH];
   logic [1:0]             unit_q  [DEPTH];
   logic [1:0]             unit_d  [DEPTH];
   logic                   wr_en_q [DEPTH];
   logic                   wr_en_d [DEPTH];
   logic [REG_ADDR_WD-1:0] addr_q  [DEPTH];
   logic [REG_ADDR_WD-1:0] addr_d  [DEPTH];
   logic                   done_q  [DEPTH];
   logic                   done_d  [DEPTH];
   logic [REG_DATA_WD-1:0] data_q  [DEPTH];
   logic [REG_DATA_WD-1:0] data_d  [DEPTH];
   logic [4:0]             inflight_q;
   logic [4:0]             inflight_d;

   // Stage in which a unit's result arrives; 0 never matches a stage.
   function automatic int unsigned unit_lat(input logic [1:0] unit);
      case (unit)
         UNIT_PERM: return PERM_LAT;
         UNIT_LS:   return LS_LAT;
         UNIT_BR:   return BR_LAT;
         default:   return 0;
      endcase
   endfunction

   logic                   capture;
   logic [REG_DATA_WD-1:0] cap_data;
   logic [4:0]             cnt;

   always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         valid_d[i] = 1'b0;
         unit_d[i]  = '0;
         wr_en_d[i] = 1'b0;
         addr_d[i]  = '0;
         done_d[i]  = 1'b0;
         data_d[i]  = '0;
      end
      capture  = 1'b0;
      cap_data = '0;
      cnt      = '0;

      // Stage 1: new issue, suppressed by a same-cycle flush.
      if (issue_valid && !flush) begin
         valid_d[0] = 1'b1;
         unit_d[0]  = issue_unit;
         wr_en_d[0] = issue_wr_en && (issue_unit != UNIT_NONE);
         addr_d[0]  = issue_rt_addr;
         done_d[0]  = (issue_unit == UNIT_NONE);
      end

      // Stage i+1 takes stage i; stages younger than the branch are flushed.
      for (int unsigned i = 1; i < DEPTH; i++) begin
         valid_d[i] = valid_q[i-1] && !(flush && (i < BR_LAT));
         unit_d[i]  = unit_q[i-1];
         wr_en_d[i] = wr_en_q[i-1];
         addr_d[i]  = addr_q[i-1];
         capture    = valid_q[i-1] && !done_q[i-1] && (unit_lat(unit_q[i-1]) == i);
         case (unit_q[i-1])
            UNIT_PERM: cap_data = perm_data;
            UNIT_LS:   cap_data = ls_data;
            default:   cap_data = br_data;
         endcase
         done_d[i] = done_q[i-1] || capture;
         data_d[i] = capture ? cap_data : data_q[i-1];
      end

      for (int unsigned i = 0; i < DEPTH; i++) begin
         cnt = cnt + {4'b0, valid_d[i]};
      end
      inflight_d = cnt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            valid_q[i] <= 1'b0;
            unit_q[i]  <= '0;
            wr_en_q[i] <= 1'b0;
            addr_q[i]  <= '0;
            done_q[i]  <= 1'b0;
            data_q[i]  <= '0;
         end
         inflight_q <= '0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            valid_q[i] <= valid_d[i];
            unit_q[i]  <= unit_d[i];
            wr_en_q[i] <= wr_en_d[i];
            addr_q[i]  <= addr_d[i];
            done_q[i]  <= done_d[i];
            data_q[i]  <= data_d[i];
         end
         inflight_q <= inflight_d;
      end
   end

   always_comb begin
      fwd_valid = '0;
      fwd_addr  = '0;
      fwd_data  = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         fwd_valid[i]                            = valid_q[i] && wr_en_q[i] && done_q[i];
         fwd_addr[i*REG_ADDR_WD +: REG_ADDR_WD]  = addr_q[i];
         fwd_data[i*REG_DATA_WD +: REG_DATA_WD]  = data_q[i];
      end
      wb_en    = fwd_valid[DEPTH-1];
      wb_addr  = addr_q[DEPTH-1];
      wb_data  = data_q[DEPTH-1];
      inflight = inflight_q;
   end

endmodule

// File: tb/tb_odd_pipe_wb_align.sv
module tb_odd_pipe_wb_align;

   localparam int AW  = 7;
   localparam int DW  = 128;
   localparam int FAW = 16 * AW;
   localparam int FDW = 16 * DW;
   localparam int HMAX = 4096;

   logic          clk = 1'b0;
   logic          rst;
   logic          issue_valid;
   logic [1:0]    issue_unit;
   logic          issue_wr_en;
   logic [AW-1:0] issue_rt_addr;
   logic [DW-1:0] br_data, perm_data, ls_data;
   logic          flush;

   always #5 clk = ~clk;

   // Config A: defaults. Config B: BR_LAT=2. Config C: DEPTH=10, LS_LAT=8.
   logic [6:0]     a_fv;  logic [7*AW-1:0]  a_fa;  logic [7*DW-1:0]  a_fd;
   logic [9:0]     c_fv;  logic [10*AW-1:0] c_fa;  logic [10*DW-1:0] c_fd;
   logic [6:0]     b_fv;  logic [7*AW-1:0]  b_fa;  logic [7*DW-1:0]  b_fd;
   logic           a_we, b_we, c_we;
   logic [AW-1:0]  a_wa, b_wa, c_wa;
   logic [DW-1:0]  a_wd, b_wd, c_wd;
   logic [4:0]     a_in, b_in, c_in;

   odd_pipe_wb_align dut_a (
      .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_unit(issue_unit),
      .issue_wr_en(issue_wr_en), .issue_rt_addr(issue_rt_addr), .br_data(br_data),
      .perm_data(perm_data), .ls_data(ls_data), .flush(flush), .fwd_valid(a_fv),
      .fwd_addr(a_fa), .fwd_data(a_fd), .wb_en(a_we), .wb_addr(a_wa), .wb_data(a_wd),
      .inflight(a_in)
   );

   odd_pipe_wb_align #(.BR_LAT(2)) dut_b (
      .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_unit(issue_unit),
      .issue_wr_en(issue_wr_en), .issue_rt_addr(issue_rt_addr), .br_data(br_data),
      .perm_data(perm_data), .ls_data(ls_data), .flush(flush), .fwd_valid(b_fv),
      .fwd_addr(b_fa), .fwd_data(b_fd), .wb_en(b_we), .wb_addr(b_wa), .wb_data(b_wd),
      .inflight(b_in)
   );

   odd_pipe_wb_align #(.DEPTH(10), .LS_LAT(8)) dut_c (
      .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_unit(issue_unit),
      .issue_wr_en(issue_wr_en), .issue_rt_addr(issue_rt_addr), .br_data(br_data),
      .perm_data(perm_data), .ls_data(ls_data), .flush(flush), .fwd_valid(c_fv),
      .fwd_addr(c_fa), .fwd_data(c_fd), .wb_en(c_we), .wb_addr(c_wa), .wb_data(c_wd),
      .inflight(c_in)
   );

   int tests = 0;
   int fails = 0;
   int cyc_n = 0;     // rising edges taken since the bench started issuing
   int last_rst = 0;  // instructions sampled at or before this edge are dropped
   bit use_fixed = 1'b0;

   // Input history, indexed by the edge that sampled it.
   logic          hv  [HMAX];
   logic [1:0]    hu  [HMAX];
   logic          hw  [HMAX];
   logic [AW-1:0] ha  [HMAX];
   logic          hfl [HMAX];
   logic [DW-1:0] hbr [HMAX];
   logic [DW-1:0] hpm [HMAX];
   logic [DW-1:0] hls [HMAX];

   typedef struct packed {
      logic          v;
      logic          fv;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;

   // Expected content of stage k after edge cc, derived per instruction:
   // issued at edge e, it sits in stage cc-e+1 and owns the unit result seen at edge e+lat.
   function automatic ent_t model(int cc, int k, int brl, int perml, int lsl);
      ent_t r;
      int   e, lat;
      logic done;
      r = '0;
      e = cc - k + 1;
      if (e < 1 || e <= last_rst) return r;
      if (!hv[e] || hfl[e]) return r;
      for (int f = e + 1; f <= e + brl - 1 && f <= cc; f++)
         if (hfl[f]) return r;
      case (hu[e])
         2'd0:    lat = perml;
         2'd1:    lat = lsl;
         2'd2:    lat = brl;
         default: lat = 0;
      endcase
      done = (hu[e] == 2'd3) || (k > lat);
      r.v  = 1'b1;
      r.a  = ha[e];
      r.fv = done && hw[e] && (hu[e] != 2'd3);
      if (done && hu[e] != 2'd3) begin
         case (hu[e])
            2'd0:    r.d = hpm[e + lat];
            2'd1:    r.d = hls[e + lat];
            default: r.d = hbr[e + lat];
         endcase
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s edge=%0d got=%0h exp=%0h", tag, cyc_n, obs, exp);
      end
   endtask

   task automatic check_cfg(input string nm, input int depth, input int brl, input int perml,
                            input int lsl, input logic [15:0] fv, input logic [FAW-1:0] fa,
                            input logic [FDW-1:0] fd, input logic we, input logic [AW-1:0] wa,
                            input logic [DW-1:0] wd, input logic [4:0] infl);
      ent_t       m;
      logic [15:0] exp_fv;
      int          cnt;
      ent_t        last;
      exp_fv = '0;
      cnt    = 0;
      last   = '0;
      for (int k = 1; k <= depth; k++) begin
         m = model(cyc_n, k, brl, perml, lsl);
         exp_fv[k-1] = m.fv;
         if (m.v) cnt++;
         if (m.fv) begin
            chk({nm, " fwd_addr"}, DW'(fa[(k-1)*AW +: AW]), DW'(m.a));
            chk({nm, " fwd_data"}, fd[(k-1)*DW +: DW], m.d);
         end
         if (k == depth) last = m;
      end
      chk({nm, " fwd_valid"}, DW'(fv), DW'(exp_fv));
      chk({nm, " wb_en"}, DW'(we), DW'(last.fv));
      if (last.fv) begin
         chk({nm, " wb_addr"}, DW'(wa), DW'(last.a));
         chk({nm, " wb_data"}, wd, last.d);
      end
      chk({nm, " inflight"}, DW'(infl), DW'(cnt));
   endtask

   task automatic check_all();
      check_cfg("A", 7, 1, 3, 6, 16'(a_fv), FAW'(a_fa), FDW'(a_fd), a_we, a_wa, a_wd, a_in);
      check_cfg("B", 7, 2, 3, 6, 16'(b_fv), FAW'(b_fa), FDW'(b_fd), b_we, b_wa, b_wd, b_in);
      check_cfg("C", 10, 1, 3, 8, 16'(c_fv), FAW'(c_fa), FDW'(c_fd), c_we, c_wa, c_wd, c_in);
   endtask

   task automatic cyc(input logic iv, input logic [1:0] u, input logic wr,
                      input logic [AW-1:0] rt, input logic fl);
      issue_valid   = iv;
      issue_unit    = u;
      issue_wr_en   = wr;
      issue_rt_addr = rt;
      flush         = fl;
      br_data       = {$urandom, $urandom, $urandom, $urandom};
      ls_data       = {$urandom, $urandom, $urandom, $urandom};
      perm_data     = use_fixed ? {16{8'hA5}} : {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      cyc_n++;
      hv[cyc_n]  = iv && !rst;
      hu[cyc_n]  = u;
      hw[cyc_n]  = wr;
      ha[cyc_n]  = rt;
      hfl[cyc_n] = fl && !rst;
      hbr[cyc_n] = br_data;
      hpm[cyc_n] = perm_data;
      hls[cyc_n] = ls_data;
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, 1'b0, '0, 1'b0);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, " rst fwd_valid"}, DW'(a_fv), '0);
      chk({nm, " rst fwd_data"}, a_fd[DW-1:0] | a_fd[6*DW +: DW], '0);
      chk({nm, " rst wb_en"}, DW'(a_we), '0);
      chk({nm, " rst wb_addr"}, DW'(a_wa), '0);
      chk({nm, " rst wb_data"}, a_wd, '0);
      chk({nm, " rst inflight"}, DW'(a_in | b_in | c_in), '0);
      chk({nm, " rst fwd_valid BC"}, DW'(b_fv) | DW'(c_fv), '0);
   endtask

   initial begin
      rst = 1'b1;
      issue_valid = 1'b0; issue_unit = '0; issue_wr_en = 1'b0; issue_rt_addr = '0;
      br_data = '0; perm_data = '0; ls_data = '0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_zero("init");
      rst = 1'b0;
      last_rst = 0;

      // Single permute with a recognisable result.
      use_fixed = 1'b1;
      cyc(1'b1, 2'd0, 1'b1, 7'd5, 1'b0);
      idle(10);
      use_fixed = 1'b0;

      // Back-to-back branch, permute, load.
      cyc(1'b1, 2'd2, 1'b1, 7'd1, 1'b0);
      cyc(1'b1, 2'd0, 1'b1, 7'd2, 1'b0);
      cyc(1'b1, 2'd1, 1'b1, 7'd3, 1'b0);
      idle(11);

      // No-result unit and a non-writing permute.
      cyc(1'b1, 2'd3, 1'b1, 7'd9, 1'b0);
      cyc(1'b1, 2'd0, 1'b0, 7'd10, 1'b0);
      idle(11);

      // Flush: branch then younger permute, flush with a new issue pending.
      cyc(1'b1, 2'd2, 1'b1, 7'd4, 1'b0);
      cyc(1'b1, 2'd0, 1'b1, 7'd6, 1'b0);
      cyc(1'b1, 2'd1, 1'b1, 7'd7, 1'b1);
      idle(11);

      // Reset with three instructions in flight.
      cyc(1'b1, 2'd0, 1'b1, 7'd11, 1'b0);
      cyc(1'b1, 2'd1, 1'b1, 7'd12, 1'b0);
      cyc(1'b1, 2'd2, 1'b1, 7'd13, 1'b0);
      rst = 1'b1;
      last_rst = cyc_n;
      #1;
      chk_zero("mid");
      cyc(1'b1, 2'd0, 1'b1, 7'd14, 1'b0);
      cyc(1'b0, 2'd0, 1'b0, 7'd0, 1'b0);
      #2;
      rst = 1'b0;
      idle(12);

      // Randomised traffic with occasional flushes.
      for (int i = 0; i < 400; i++) begin
         cyc(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 4) != 0), 7'($urandom), 1'($urandom_range(0, 7) == 0));
      end
      idle(12);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
